radix8_pp_generator: RTL



---
 rtl/radix8_pkg.sv | 35 +++
 rtl/booth_r8_select.sv | 34 +++
 rtl/radix8_pp_generator.sv | 107 ++++++++++
 3 files changed

// File: rtl/radix8_pkg.sv
// radix8_pkg
//   Shared widths, the radix-8 Booth digit type and the digit recode
//   function for the radix-8 partial-product generator and its bench.
package radix8_pkg;

    localparam int A_W         = 8;   // operand width
    localparam int MULT_W      = 16;  // width at which multiples are formed
    localparam int P1_W        = 16;  // digit 0 product width (weight 2^0)
    localparam int P2_W        = 13;  // digit 1 product width (weight 2^3)
    localparam int P3_W        = 10;  // digit 2 product width (weight 2^6)
    localparam int DIGIT_SHIFT = 3;   // bits consumed per Booth digit
    localparam int NUM_DIGITS  = 3;

    // Signed-magnitude Booth digit: value = neg ? -mag : mag, mag in 0..4.
    typedef struct packed {
        logic       neg;
        logic [2:0] mag;
    } booth_digit_t;

    // grp = {x3, x2, x1, x0}; digit = -4*x3 + 2*x2 + x1 + x0.
    // 4'b1111 evaluates to zero and comes back with neg cleared.
    function automatic booth_digit_t booth_recode(input logic [3:0] grp);
        booth_digit_t d;
        int           v;
        v = 0;
        if (grp[3]) v = v - 4;
        if (grp[2]) v = v + 2;
        if (grp[1]) v = v + 1;
        if (grp[0]) v = v + 1;
        d.neg = (v < 0);
        d.mag = (v < 0) ? 3'(-v) : 3'(v);
        return d;
    endfunction

endpackage

// File: rtl/booth_r8_select.sv
// booth_r8_select
//   Combinational radix-8 Booth digit decode, multiple select and negate.
//   Ports:
//     i_grp  4-bit multiplier group {b[3i+2], b[3i+1], b[3i], b[3i-1]}
//     i_a    16-bit extended multiplicand A
//     i_a3   16-bit precomputed 3A
//     o_pp   16-bit digit * A (mod 2^16)
module booth_r8_select
    import radix8_pkg::*;
(
    input  logic [3:0]        i_grp,
    input  logic [MULT_W-1:0] i_a,
    input  logic [MULT_W-1:0] i_a3,
    output logic [MULT_W-1:0] o_pp
);

    booth_digit_t      w_digit;
    logic [MULT_W-1:0] w_mult;

    always_comb begin
        w_digit = booth_recode(i_grp);
        w_mult  = '0;
        case (w_digit.mag)
            3'd1:    w_mult = i_a;
            3'd2:    w_mult = {i_a[MULT_W-2:0], 1'b0};
            3'd3:    w_mult = i_a3;
            3'd4:    w_mult = {i_a[MULT_W-3:0], 2'b00};
            default: w_mult = '0;
        endcase
        // Negating a zero multiple still gives zero, so neg with mag 0 is safe.
        o_pp = w_digit.neg ? (~w_mult + MULT_W'(1)) : w_mult;
    end

endmodule

// File: rtl/radix8_pp_generator.sv
// radix8_pp_generator
//   Two-stage pipelined radix-8 Booth partial-product generator for an
//   8x8 multiply. Outputs P1 (weight 2^0), P2 (weight 2^3), P3 (weight 2^6);
//   P1 + (P2<<3) + (P3<<6) mod 2^16 equals a*b.
//   Ports:
//     clk, rst           clock, synchronous active-low reset
//     in_valid/in_ready  operand handshake, a_in multiplicand, b_in multiplier
//     out_valid/out_ready result handshake
//     P1_out/P2_out/P3_out weighted partial products (16/13/10 bits)
module radix8_pp_generator
    import radix8_pkg::*;
#(
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [A_W-1:0]  a_in,
    input  logic [A_W-1:0]  b_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [P1_W-1:0] P1_out,
    output logic [P2_W-1:0] P2_out,
    output logic [P3_W-1:0] P3_out
);

    // Stage 1: extended operands and the hard multiple
    logic              r_s1_valid;
    logic [MULT_W-1:0] r_s1_a;
    logic [MULT_W-1:0] r_s1_a3;
    logic [A_W:0]      r_s1_b;

    // Stage 2: selected partial products
    logic              r_s2_valid;
    logic [P1_W-1:0]   r_p1;
    logic [P2_W-1:0]   r_p2;
    logic [P3_W-1:0]   r_p3;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic [MULT_W-1:0] w_a_ext;
    logic [MULT_W-1:0] w_a3;
    logic [A_W:0]      w_b_ext;
    logic [A_W+1:0]    w_bx;
    logic [NUM_DIGITS-1:0][3:0]        w_grp;
    logic [NUM_DIGITS-1:0][MULT_W-1:0] w_pp;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_a_ext = SIGNED_MODE ? {{(MULT_W-A_W){a_in[A_W-1]}}, a_in}
                                 : {{(MULT_W-A_W){1'b0}}, a_in};
    assign w_b_ext = {SIGNED_MODE ? b_in[A_W-1] : 1'b0, b_in};
    assign w_a3    = w_a_ext + {w_a_ext[MULT_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_a3    <= '0;
            r_s1_b     <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= w_a_ext;
                r_s1_a3 <= w_a3;
                r_s1_b  <= w_b_ext;
            end
        end
    end

    // Append b[-1] = 0 so digit i is simply w_bx[3i+3 -: 4].
    assign w_bx = {r_s1_b, 1'b0};

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_grp[gi] = w_bx[DIGIT_SHIFT*gi+3 -: 4];
        booth_r8_select u_sel (
            .i_grp (w_grp[gi]),
            .i_a   (r_s1_a),
            .i_a3  (r_s1_a3),
            .o_pp  (w_pp[gi])
        );
    end

    // Bubbles load zeros so a downstream adder without valid sees nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_p3       <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_p1       <= r_s1_valid ? w_pp[0][P1_W-1:0] : '0;
            r_p2       <= r_s1_valid ? w_pp[1][P2_W-1:0] : '0;
            r_p3       <= r_s1_valid ? w_pp[2][P3_W-1:0] : '0;
        end
    end

    assign out_valid = r_s2_valid;
    assign P1_out    = r_p1;
    assign P2_out    = r_p2;
    assign P3_out    = r_p3;

endmodule
